// File: rtl/nor_emu_pkg.sv
// Shared opcodes, FSM state encoding and status-register layout for the
// serial NOR flash emulator.
package nor_emu_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_FREAD = 8'h0B;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_PP    = 8'h02;

  localparam int ST_WIP = 0;
  localparam int ST_WEL = 1;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    RDATA,
    STAT,
    PDATA,
    IGNORE
  } state_t;

  function automatic logic [7:0] status_byte(input logic wel, input logic wip);
    logic [7:0] s;
    s         = '0;
    s[ST_WEL] = wel;
    s[ST_WIP] = wip;
    return s;
  endfunction

endpackage

// File: rtl/nor_emu_sync.sv
// Brings the asynchronous SPI pins into the clk domain and flags sck/csb edges.
// sio gets a third stage so sampled data lines up with the delayed sck edge.
module nor_emu_sync (
  input  logic       clk,
  input  logic       sck,
  input  logic       csb,
  input  logic [3:0] sio_i,
  output logic       sck_rise,
  output logic       sck_fall,
  output logic       csb_fall,
  output logic       csb_rise,
  output logic       csb_s,
  output logic [3:0] sio_s
);

  logic       sck_p0, sck_p1, sck_p2;
  logic       csb_p0, csb_p1, csb_p2;
  logic [3:0] sio_p0, sio_p1, sio_p2;

  // p0/p1: metastability chain, p2: previous value for edge detection
  always_ff @(posedge clk) begin
    sck_p0 <= sck;
    sck_p1 <= sck_p0;
    sck_p2 <= sck_p1;
    csb_p0 <= csb;
    csb_p1 <= csb_p0;
    csb_p2 <= csb_p1;
    sio_p0 <= sio_i;
    sio_p1 <= sio_p0;
    sio_p2 <= sio_p1;
  end

  assign sck_rise = sck_p1 & ~sck_p2;
  assign sck_fall = ~sck_p1 & sck_p2;
  assign csb_fall = ~csb_p1 & csb_p2;
  assign csb_rise = csb_p1 & ~csb_p2;
  assign csb_s    = csb_p1;
  assign sio_s    = sio_p2;

endmodule

// File: rtl/nor_emu.sv
// Clocked serial NOR flash emulator: read, fast read, status, write enable and
// page program with AND semantics, oversampling the SPI pins with clk.
module nor_emu
  import nor_emu_pkg::*;
#(
  parameter int LANES        = 4,
  parameter int DUMMY_CYCLES = 10,
  parameter int MEM_DEPTH    = 512,
  parameter int PAGE_SIZE    = 256,
  parameter int PROG_CYCLES  = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sck,
  input  logic                         csb,
  input  logic [3:0]                   sio_i,
  output logic [3:0]                   sio_o,
  output logic [3:0]                   sio_oe,
  input  logic                         bd_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] bd_addr,
  input  logic [7:0]                   bd_wdata,
  output logic                         wip,
  output logic                         wel
);

  localparam int AW     = $clog2(MEM_DEPTH);
  localparam int EPB    = 8 / LANES;
  localparam int AEDGES = 24 / LANES;
  localparam int WCW    = $clog2(PROG_CYCLES + 1);
  localparam logic [AW-1:0] PMASK = AW'(PAGE_SIZE - 1);
  localparam logic [3:0] OE_MASK = (LANES == 1) ? 4'b0010 :
                                   (LANES == 2) ? 4'b0011 : 4'b1111;

  logic             sck_rise, sck_fall, csb_fall, csb_rise, csb_s;
  logic [3:0]       sio_s;
  logic [LANES-1:0] din;

  state_t           state_q;
  logic [7:0]       op_q;
  logic [7:0]       obyte_q;
  logic [7-LANES:0] sh_q;
  logic [AW-1:0]    addr_q;
  logic [4:0]       cnt_q;
  logic [2:0]       ocnt_q;
  logic [15:0]      dcnt_q;
  logic [WCW-1:0]   wcnt_q;
  logic             wip_q, wel_q, cmt_q;

  logic [7:0]       byte_d, stat_d;
  logic [AW-1:0]    addr_sh_d, addr_inc_d, addr_pg_d;
  logic             last_bit, last_addr, pw_en;
  logic             unused_sio;

  logic [7:0]       mem [MEM_DEPTH];

  nor_emu_sync u_sync (
    .clk      (clk),
    .sck      (sck),
    .csb      (csb),
    .sio_i    (sio_i),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .csb_fall (csb_fall),
    .csb_rise (csb_rise),
    .csb_s    (csb_s),
    .sio_s    (sio_s)
  );

  function automatic logic [3:0] lane_out(input logic [3:0] hi);
    logic [3:0] o;
    o = '0;
    if (LANES == 1)      o[1]   = hi[3];
    else if (LANES == 2) o[1:0] = hi[3:2];
    else                 o      = hi;
    return o;
  endfunction

  always_comb begin
    din        = sio_s[LANES-1:0];
    unused_sio = ^sio_s;
    byte_d     = {sh_q, din};
    addr_sh_d  = {addr_q[AW-1-LANES:0], din};
    addr_inc_d = addr_q + AW'(1);
    // program address wraps inside its page, upper bits stay put
    addr_pg_d  = (addr_q & ~PMASK) | (addr_inc_d & PMASK);
    last_bit   = (cnt_q == 5'(EPB - 1));
    last_addr  = (cnt_q == 5'(AEDGES - 1));
    stat_d     = status_byte(wel_q, wip_q);
    pw_en      = !rst && !csb_rise && sck_rise && (state_q == PDATA) && last_bit;
  end

  // array is never reset so preloaded and programmed contents survive rst
  always_ff @(posedge clk) begin
    if (bd_we && csb_s)
      mem[bd_addr] <= bd_wdata;
    else if (pw_en)
      mem[addr_q] <= mem[addr_q] & byte_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sio_o   <= '0;
      sio_oe  <= '0;
      wip_q   <= 1'b0;
      wel_q   <= 1'b0;
      cmt_q   <= 1'b0;
      wcnt_q  <= '0;
      cnt_q   <= '0;
      ocnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      if (wip_q) begin
        if (wcnt_q == '0) begin
          wip_q <= 1'b0;
          wel_q <= 1'b0;
        end else begin
          wcnt_q <= wcnt_q - WCW'(1);
        end
      end

      if (csb_rise) begin
        state_q <= IDLE;
        sio_oe  <= '0;
        cnt_q   <= '0;
        if (cmt_q) begin
          cmt_q  <= 1'b0;
          wip_q  <= 1'b1;
          wcnt_q <= WCW'(PROG_CYCLES - 1);
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (csb_fall) begin
              state_q <= CMD;
              cnt_q   <= '0;
            end
          end

          CMD: begin
            if (sck_rise) begin
              sh_q <= byte_d[7-LANES:0];
              if (!last_bit) begin
                cnt_q <= cnt_q + 5'd1;
              end else begin
                cnt_q <= '0;
                op_q  <= byte_d;
                if (wip_q && byte_d != OP_RDSR) begin
                  state_q <= IGNORE;
                end else begin
                  case (byte_d)
                    OP_READ, OP_FREAD, OP_PP: state_q <= ADDR;
                    OP_RDSR: begin
                      state_q <= STAT;
                      obyte_q <= stat_d;
                      ocnt_q  <= '0;
                    end
                    OP_WREN: begin
                      wel_q   <= 1'b1;
                      state_q <= IGNORE;
                    end
                    OP_WRDI: begin
                      wel_q   <= 1'b0;
                      state_q <= IGNORE;
                    end
                    default: state_q <= IGNORE;
                  endcase
                end
              end
            end
          end

          ADDR: begin
            if (sck_rise) begin
              addr_q <= addr_sh_d;
              if (!last_addr) begin
                cnt_q <= cnt_q + 5'd1;
              end else begin
                cnt_q  <= '0;
                ocnt_q <= '0;
                dcnt_q <= '0;
                if (op_q == OP_PP) begin
                  state_q <= wel_q ? PDATA : IGNORE;
                end else if (op_q == OP_FREAD && DUMMY_CYCLES != 0) begin
                  state_q <= DUMMY;
                end else begin
                  state_q <= RDATA;
                  obyte_q <= mem[addr_sh_d];
                end
              end
            end
          end

          DUMMY: begin
            if (sck_rise) begin
              if (dcnt_q == 16'(DUMMY_CYCLES - 1)) begin
                state_q <= RDATA;
                obyte_q <= mem[addr_q];
              end else begin
                dcnt_q <= dcnt_q + 16'd1;
              end
            end
          end

          RDATA, STAT: begin
            if (sck_fall) begin
              sio_o  <= lane_out(obyte_q[7:4]);
              sio_oe <= OE_MASK;
              if (ocnt_q == 3'(EPB - 1)) begin
                ocnt_q <= '0;
                if (state_q == RDATA) begin
                  addr_q  <= addr_inc_d;
                  obyte_q <= mem[addr_inc_d];
                end else begin
                  obyte_q <= stat_d;
                end
              end else begin
                ocnt_q  <= ocnt_q + 3'd1;
                obyte_q <= obyte_q << LANES;
              end
            end
          end

          PDATA: begin
            if (sck_rise) begin
              sh_q <= byte_d[7-LANES:0];
              if (!last_bit) begin
                cnt_q <= cnt_q + 5'd1;
              end else begin
                cnt_q  <= '0;
                addr_q <= addr_pg_d;
                cmt_q  <= 1'b1;
              end
            end
          end

          IGNORE: ;
        endcase
      end
    end
  end

  assign wip = wip_q;
  assign wel = wel_q;

endmodule

// File: doc/nor_emu.md
Name: nor_emu

Overview:
Synthesizable, clocked emulator of a serial NOR flash. It replaces the fixed-width, event-driven read-only flash models used in simulation with one parametrised block. The bus width is selectable (1-1-1, 2-2-2 or 4-4-4). The block adds status read, write-enable latching, page program with flash AND-semantics, and a busy (WIP) period. It sits in the testbench, or on an FPGA test fixture, on the qspi_sck/qspi_csb/qspi_sio pins. It oversamples the SPI pins with its own system clock.

Parameters:
LANES, 4, data lanes for every phase: 1, 2 or 4.
DUMMY_CYCLES, 10, sck cycles between the last address edge and the first data edge for opcode 0x0B.
MEM_DEPTH, 512, bytes of array; the address is taken modulo MEM_DEPTH (power of two).
PAGE_SIZE, 256, program wrap boundary in bytes (power of two, at most MEM_DEPTH).
PROG_CYCLES, 64, clk cycles that WIP stays high after a program commits.

Ports:
clk  in  1  system clock; must be at least 8x the sck frequency.
rst  in  1  synchronous, active-high reset.
sck  in  1  SPI clock (asynchronous to clk).
csb  in  1  chip select, active low (asynchronous).
sio_i  in  4  pad inputs.
sio_o  out  4  pad output data.
sio_oe  out  4  pad output enables.
bd_we  in  1  backdoor byte write for preload; ignored while csb is low.
bd_addr  in  $clog2(MEM_DEPTH)  backdoor address.
bd_wdata  in  8  backdoor data.
wip  out  1  status bit 0 mirror.
wel  out  1  status bit 1 mirror.

Behaviour:
- Synchronisation:
  - sck, csb and sio_i each pass through a 2-flop synchroniser. sio_i gets one extra stage so it stays aligned with the sck edge detect.
  - Rise and fall are detected on the synchronised sck.
- Sampling and driving:
  - Input is sampled on a detected sck rise; output is updated on a detected sck fall.
  - sio_o changes 3 clk cycles after the physical sck fall.
  - Every phase is MSB-first, LANES bits per edge, 8/LANES edges per byte.
- Lane mapping:
  - LANES=1: input on sio[0], output on sio[1].
  - LANES=2: both directions on sio[1:0].
  - LANES=4: both directions on sio[3:0].
- Reset: sio_o=0, sio_oe=0, wip=0, wel=0, FSM=IDLE, WIP counter=0. Array contents are preserved.
- FSM states: IDLE, CMD, ADDR, DUMMY, RDATA, STAT, PDATA, IGNORE.
  - IDLE -> CMD on synchronised csb fall.
  - CMD -> next state on the 8th command bit, by opcode:
    - 0x03: ADDR (no dummy), then RDATA.
    - 0x0B: ADDR, then DUMMY, then RDATA.
    - 0x05: STAT.
    - 0x06: set WEL, then IGNORE.
    - 0x04: clear WEL, then IGNORE.
    - 0x02: ADDR, then PDATA if WEL=1, otherwise IGNORE.
    - Any other opcode: IGNORE.
  - While WIP=1, every opcode except 0x05 goes to IGNORE.
  - ADDR collects 24 bits; the low $clog2(MEM_DEPTH) bits are used.
  - DUMMY counts DUMMY_CYCLES sck rises; with DUMMY_CYCLES=0 it passes straight through.
- RDATA:
  - sio_oe asserts on the first sck fall after the last address or dummy rise. The enable mask is LANES-wide; for LANES=1 it is 4'b0010.
  - Bytes stream from the current address. The address increments per byte and wraps MEM_DEPTH-1 -> 0.
- STAT: drives {6'b0, WEL, WIP} repeatedly for as long as csb stays low.
- PDATA:
  - Each completed byte is written as array[a] &= byte; bits only go 1 -> 0.
  - The address wraps within the page: the low $clog2(PAGE_SIZE) bits increment, the upper bits are held.
  - A program counts as committed when at least 1 full byte has been written.
- csb rise (synchronised), from any state:
  - sio_oe=0, FSM=IDLE, any partial byte is discarded.
  - If a program committed: WIP=1 for PROG_CYCLES clk cycles, then WIP=0 and WEL=0.
  - If PDATA ended with 0 bytes: no WIP period, WEL is kept.
- Backdoor write: takes effect in the same cycle as bd_we; dropped while csb is low.
- rst asserted mid-transaction: immediate IDLE, outputs off, partial program bytes already written stay written.

Decomposition:
- nor_emu_pkg: opcode localparams (OP_READ, OP_FREAD, OP_RDSR, OP_WREN, OP_WRDI, OP_PP), the state_t enum, and the status bit indices.
- Sub-module nor_emu_sync: synchroniser plus edge detector for sck, csb and sio_i. It outputs sck_rise, sck_fall, csb_fall, csb_rise and sio_s.

Test Plan:
1. LANES=4, DUMMY_CYCLES=10, preload 0x000=A5, 0x001=3C. Send 0x0B, address 0x000000, 4 data bytes -> nibbles A,5,3,C; sio_oe=4'hF only in RDATA.
2. LANES=1, opcode 0x03, address 0x0001FF, read 2 bytes -> byte at 0x1FF, then byte at 0x000 (wrap). Output appears on sio[1] only.
3. 0x02 without WREN, data 0x00 -> array unchanged, wip stays 0. Then 0x06, then 0x02 to address 0x0FF with data 0x0F,0xF0 over preloaded FF,FF -> 0x0FF=0F, 0x000=F0 (page wrap). wip=1 for 64 clk, then wel=0.
4. During WIP, send 0x05 -> status byte 0x03. Send 0x03 during WIP -> sio_oe stays 0.
5. LANES=2: csb rises after 3 command edges, then a full 0x03 read -> the aborted transaction has no effect and the read is correct. rst pulsed mid-RDATA -> sio_oe=0 on the next cycle, FSM=IDLE.
